// File: rtl/seg7_blink_driver_if.sv
// Avalon-MM slave bus for the 7-segment blink driver register block.
// Zero-wait-state: readdata is combinational from address.
interface seg7_blink_driver_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/seg7_blink_driver.sv
// One 7-segment digit: active-high PIO pattern in, registered active-low pins out,
// with software enable and a programmable half-period blink.
module seg7_blink_driver #(
  parameter int CNT_W          = 26,
  parameter int DEFAULT_PERIOD = 25000000
) (
  input  logic                 clk,
  input  logic                 reset,
  seg7_blink_driver_if.slave   avs,
  input  logic [6:0]           seg_in,
  output logic [6:0]           hex_n
);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;

  localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  logic             enable_q;
  logic             blink_en_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [6:0]       seg_q;
  logic             show;
  logic             wr, wr_ctrl, wr_period;

  assign wr        = avs.chipselect & ~avs.write_n;
  assign wr_ctrl   = wr & (avs.address == ADDR_CTRL);
  assign wr_period = wr & (avs.address == ADDR_PERIOD);

  assign show = enable_q & (~blink_en_q | phase_q);

  // Register block
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q   <= 1'b1;
      blink_en_q <= 1'b0;
      period_q   <= PERIOD_RST;
    end else begin
      if (wr_ctrl) begin
        enable_q   <= avs.writedata[0];
        blink_en_q <= avs.writedata[1];
      end
      if (wr_period)
        period_q <= avs.writedata[CNT_W-1:0];
    end
  end

  // Blink next-state. A CTRL write turning blink on is covered by the first
  // branch, since blink_en_q is still 0 on that edge.
  always_comb begin
    cnt_d   = cnt_q + ONE;
    phase_d = phase_q;
    if (!blink_en_q) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (wr_period) begin
      cnt_d   = '0;
    end else if (period_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == period_q - ONE) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Two-stage datapath: capture the pattern, then gate and invert onto the pins
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= '0;
      hex_n <= 7'h7F;
    end else begin
      seg_q <= seg_in;
      hex_n <= ~(show ? seg_q : 7'h00);
    end
  end

  always_comb begin
    avs.readdata = '0;
    if (avs.chipselect) begin
      case (avs.address)
        ADDR_CTRL:   avs.readdata = {30'd0, blink_en_q, enable_q};
        ADDR_PERIOD: avs.readdata = 32'(period_q);
        ADDR_STATUS: avs.readdata = {30'd0, show, phase_q};
        default:     avs.readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_blink_driver.sv
// Directed bench for seg7_blink_driver: reset, latency, enable, blink cadence,
// period edge cases and mid-blink reset.
module tb_seg7_blink_driver;
  logic       clk;
  logic       reset;
  logic [6:0] seg_in;
  logic [6:0] hex_n;
  int         n_chk;
  int         n_err;
  logic [31:0] rd_val;

  seg7_blink_driver_if bus ();

  seg7_blink_driver dut (
    .clk    (clk),
    .reset  (reset),
    .avs    (bus),
    .seg_in (seg_in),
    .hex_n  (hex_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    step();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    bus.address    = a;
    #1;
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  // j = 1..12 after blink start with PERIOD=3: pins blanked / phase value
  logic [12:1] blank_v;
  logic [12:1] phase_v;

  initial begin
    n_chk = 0;
    n_err = 0;
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    reset = 1'b1;
    seg_in = 7'h3F;

    // 1: reset and first pattern
    step();
    chk("rst_hex", 32'(hex_n), 32'h7F);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_1", 32'(hex_n), 32'h7F);
    step();
    chk("post_rst_2", 32'(hex_n), 32'h40);
    rd(2'd2, rd_val); chk("status_rst", rd_val, 32'h3);

    // 2: two-clock latency, no intermediate value
    seg_in = 7'h06;
    step(); step();
    chk("lat_06", 32'(hex_n), 32'h79);
    seg_in = 7'h5B;
    step();
    chk("lat_mid", 32'(hex_n), 32'h79);
    step();
    chk("lat_5b", 32'(hex_n), 32'h24);

    // 3: enable off/on
    wr(2'd0, 32'h0);
    chk("dis_edge", 32'(hex_n), 32'h24);
    step();
    chk("dis_blank", 32'(hex_n), 32'h7F);
    rd(2'd2, rd_val); chk("status_dis", rd_val, 32'h1);
    wr(2'd0, 32'h1);
    chk("en_edge", 32'(hex_n), 32'h7F);
    step();
    chk("en_back", 32'(hex_n), 32'h24);
    rd(2'd0, rd_val); chk("ctrl_rd", rd_val, 32'h1);

    // 4: blink with PERIOD=3
    seg_in = 7'h7F;
    wr(2'd1, 32'd3);
    rd(2'd1, rd_val); chk("period_rd3", rd_val, 32'd3);
    wr(2'd0, 32'h3);
    chk("blink_start", 32'(hex_n), 32'h00);
    blank_v = 12'b111000111000;
    phase_v = 12'b100011100011;
    for (int j = 1; j <= 12; j++) begin
      step();
      chk($sformatf("blink_hex_%0d", j), 32'(hex_n), blank_v[j] ? 32'h7F : 32'h00);
      rd(2'd2, rd_val);
      chk($sformatf("blink_ph_%0d", j), 32'(rd_val[0]), 32'(phase_v[j]));
    end

    // 5: PERIOD=0 stops toggling, PERIOD=1 toggles every clock
    step(); step(); step();
    rd(2'd2, rd_val); chk("pre_p0_phase", rd_val, 32'h0);
    wr(2'd1, 32'd0);
    chk("p0_w", 32'(hex_n), 32'h7F);
    step();
    chk("p0_w1", 32'(hex_n), 32'h7F);
    for (int j = 2; j <= 6; j++) begin
      step();
      chk($sformatf("p0_hold_%0d", j), 32'(hex_n), 32'h00);
    end
    rd(2'd2, rd_val); chk("p0_status", rd_val, 32'h3);
    wr(2'd1, 32'd1);
    for (int j = 1; j <= 6; j++) begin
      step();
      chk($sformatf("p1_hex_%0d", j), 32'(hex_n), (j % 2 == 1) ? 32'h00 : 32'h7F);
    end
    rd(2'd1, rd_val); chk("period_rd1", rd_val, 32'd1);

    // 6: reset while blanked
    step();
    rd(2'd2, rd_val); chk("pre_rst_status", rd_val, 32'h0);
    seg_in = 7'h6D;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_hex", 32'(hex_n), 32'h7F);
    rd(2'd0, rd_val); chk("rst_ctrl", rd_val, 32'h1);
    rd(2'd1, rd_val); chk("rst_period", rd_val, 32'd25000000);
    rd(2'd2, rd_val); chk("rst_status", rd_val, 32'h3);
    rd(2'd3, rd_val); chk("addr3_rd", rd_val, 32'h0);
    step();
    chk("rst_lat1", 32'(hex_n), 32'h7F);
    step();
    chk("rst_lat2", 32'(hex_n), 32'h12);

    // Ignored writes and truncated PERIOD
    wr(2'd2, 32'hFFFF_FFFF);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd0, rd_val); chk("ro_ctrl", rd_val, 32'h1);
    rd(2'd1, rd_val); chk("ro_period", rd_val, 32'd25000000);
    wr(2'd1, 32'hFC00_0005);
    rd(2'd1, rd_val); chk("period_trunc", rd_val, 32'd5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
